// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_if
// Brief    : Instruction handshake, register-file, ALU and status bundle for
//            the ALU execute controller.
// Revision : 1.0
// ============================================================================
interface alu_exec_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              instr_ready;
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_opcode;
  logic              alu_carry_in;
  logic [DATA_W-1:0] alu_c;
  logic [4:0]        alu_flags;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [4:0]        psr;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
    output instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode,
           alu_carry_in, rf_we, rf_waddr, rf_wdata, psr, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_c, alu_flags,
    input  instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode,
           alu_carry_in, rf_we, rf_waddr, rf_wdata, psr, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : Four-state execute sequencer (IDLE/READ/EXEC/WB) for a 16-bit
//            ALU; optional macro CARRY_CHAIN_EN feeds psr carry to ADD/ADDI.
// Revision : 1.0
// ============================================================================
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_exec_ctrl_if.master bus
);

  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SHIFTS = 4'h8;
  localparam logic [3:0] OP_SUBI   = 4'h9;
  localparam logic [3:0] OP_CMPI   = 4'hB;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_CMP   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] res;
  logic [4:0]        flg;
  logic [4:0]        psr_q;

  logic [3:0]        op;
  logic [3:0]        ext;
  logic              is_legal;
  logic              is_imm;
  logic              writes_rf;
  logic              carry_sel;
  logic [DATA_W-1:0] imm_sext;

  assign op       = ir[15:12];
  assign ext      = ir[7:4];
  assign is_legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SUBI) ||
                    (op == OP_CMPI)  || (op == OP_SHIFTS);
  assign is_imm   = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
  // Compares only update flags, so they never write the destination.
  assign writes_rf = is_legal && (op != OP_CMPI) &&
                     !((op == OP_RTYPE) && (ext == EXT_CMP));
  assign imm_sext = {{(DATA_W-8){ir[7]}}, ir[7:0]};

`ifdef CARRY_CHAIN_EN
  assign carry_sel = (((op == OP_RTYPE) && (ext == EXT_ADD)) || (op == OP_ADDI)) ?
                     psr_q[0] : 1'b0;
`else
  assign carry_sel = 1'b0;
`endif

  assign bus.psr = psr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
      res   <= '0;
      flg   <= '0;
      psr_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && bus.instr_valid) begin
        ir <= bus.instr;
      end
      if (state == S_EXEC) begin
        res <= bus.alu_c;
        flg <= bus.alu_flags;
      end
      if ((state == S_WB) && is_legal) begin
        psr_q <= flg;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.instr_ready  = 1'b0;
    bus.rf_raddr_a   = '0;
    bus.rf_raddr_b   = '0;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_opcode   = '0;
    bus.alu_carry_in = 1'b0;
    bus.rf_we        = 1'b0;
    bus.rf_waddr     = '0;
    bus.rf_wdata     = '0;
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        bus.rf_raddr_a = ir[11:8];
        bus.rf_raddr_b = ir[3:0];
        state_nxt      = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_a        = bus.rf_rdata_a;
        bus.alu_b        = is_imm ? imm_sext : bus.rf_rdata_b;
        bus.alu_opcode   = ir;
        bus.alu_carry_in = carry_sel;
        state_nxt        = S_WB;
      end
      S_WB: begin
        // A reset landing in WB must suppress the write and the pulses.
        bus.rf_waddr = ir[11:8];
        bus.rf_wdata = res;
        bus.rf_we    = writes_rf && !reset;
        bus.done     = !reset;
        bus.illegal  = !is_legal && !reset;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Brief    : Directed bench with an instruction-level reference model,
//            a behavioural ALU and a registered register file.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural ALU; flags are {NEG, ZERO, FLAG(overflow), LOW, CARRY}.
  function automatic logic [20:0] alu_fn(input logic [15:0] opw, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] c;
    logic [4:0]  f;
    int          cls;
    c = '0;
    f = '0;
    s = '0;
    case (opw[15:12])
      4'h0:    cls = (opw[7:4] == 4'h5) ? 1 : (opw[7:4] == 4'h9) ? 2 :
                     (opw[7:4] == 4'hB) ? 3 : 0;
      4'h5:    cls = 1;
      4'h9:    cls = 2;
      4'hB:    cls = 3;
      4'h8:    cls = 4;
      default: cls = 0;
    endcase
    case (cls)
      1: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        c = s[15:0];
        f = {c[15], c == 16'd0, (a[15] == b[15]) && (c[15] != a[15]), 1'b0, s[16]};
      end
      2: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[15:0];
        f = {c[15], c == 16'd0, (a[15] != b[15]) && (c[15] != a[15]), 1'b0, s[16]};
      end
      3: begin
        c = a - b;
        f = {$signed(a) < $signed(b), a == b, 1'b0, a < b, 1'b0};
      end
      4:       c = a << b[3:0];
      default: c = a ^ b;
    endcase
    return {f, c};
  endfunction

  always_comb begin
    {bus.alu_flags, bus.alu_c} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry_in);
  end

  logic [15:0] regs [16];
  logic        clr = 1'b1;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (pl_en) begin
      regs[pl_addr] <= pl_data;
    end else if (bus.rf_we) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
    bus.rf_rdata_a <= regs[bus.rf_raddr_a];
    bus.rf_rdata_b <= regs[bus.rf_raddr_b];
  end

  // Instruction-level model: an accepted word spends three cycles in flight,
  // operands come from the register file one edge after accept.
  int          cyc = 0;
  int          acc = 0;
  bit          busy = 1'b0;
  logic [15:0] m_ir = '0;
  logic [15:0] m_oa = '0;
  logic [15:0] m_ob = '0;
  logic        m_cin = 1'b0;
  logic [15:0] m_res = '0;
  logic [4:0]  m_flg = '0;
  logic [4:0]  m_psr = '0;
  bit          m_legal;
  bit          m_wr;

  always_comb begin
    m_legal = m_ir[15:12] inside {4'h0, 4'h5, 4'h9, 4'hB, 4'h8};
    m_wr    = m_legal && (m_ir[15:12] != 4'hB) &&
              !((m_ir[15:12] == 4'h0) && (m_ir[7:4] == 4'hB));
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        busy  = 1'b0;
        m_psr = '0;
      end else if (busy && (cyc - acc == 3)) begin
        if (m_legal) m_psr = m_flg;
        busy = 1'b0;
      end else if (busy && (cyc - acc == 1)) begin
        m_oa = regs[m_ir[11:8]];
        m_ob = (m_ir[15:12] inside {4'h5, 4'h9, 4'hB}) ? {{8{m_ir[7]}}, m_ir[7:0]}
                                                      : regs[m_ir[3:0]];
`ifdef CARRY_CHAIN_EN
        m_cin = (((m_ir[15:12] == 4'h0) && (m_ir[7:4] == 4'h5)) || (m_ir[15:12] == 4'h5))
                ? m_psr[0] : 1'b0;
`else
        m_cin = 1'b0;
`endif
        {m_flg, m_res} = alu_fn(m_ir, m_oa, m_ob, m_cin);
      end else if (!busy && bus.instr_valid) begin
        busy = 1'b1;
        acc  = cyc;
        m_ir = bus.instr;
      end
    end
  end

  initial begin
    int p;
    bit wb;
    forever begin
      @(negedge clk);
      p  = busy ? (cyc - acc) : -1;
      wb = (p == 2);
      chk("instr_ready", bus.instr_ready, !busy);
      chk("psr", bus.psr, m_psr);
      chk("rf_we", bus.rf_we, wb && !reset && m_wr);
      chk("done", bus.done, wb && !reset);
      chk("illegal", bus.illegal, wb && !reset && !m_legal);
      chk("alu_a", bus.alu_a, (p == 1) ? m_oa : 16'd0);
      chk("alu_b", bus.alu_b, (p == 1) ? m_ob : 16'd0);
      chk("alu_opcode", bus.alu_opcode, (p == 1) ? m_ir : 16'd0);
      chk("alu_carry_in", bus.alu_carry_in, (p == 1) ? m_cin : 1'b0);
      if (p == 0) begin
        chk("rf_raddr_a", bus.rf_raddr_a, m_ir[11:8]);
        chk("rf_raddr_b", bus.rf_raddr_b, m_ir[3:0]);
      end
      if (wb) begin
        chk("rf_waddr", bus.rf_waddr, m_ir[11:8]);
        chk("rf_wdata", bus.rf_wdata, m_res);
      end
    end
  end

  logic        cap_we;
  logic        cap_ill;
  logic [3:0]  cap_waddr;
  logic [15:0] cap_wdata;
  logic [4:0]  cap_psr;

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #2 pl_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    int t;
    bit seen;
    t = 0;
    @(negedge clk);
    while (!bus.instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", bus.instr_ready, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #2;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    seen = 1'b0;
    t    = 0;
    while (!seen && t < 10) begin
      @(negedge clk);
      if (bus.done) begin
        seen      = 1'b1;
        cap_we    = bus.rf_we;
        cap_ill   = bus.illegal;
        cap_waddr = bus.rf_waddr;
        cap_wdata = bus.rf_wdata;
      end
      t++;
    end
    chk("done_seen", seen, 1'b1);
    @(negedge clk);
    cap_psr = bus.psr;
  endtask

  initial begin
    logic [4:0]  psr_before;
    logic        rdy [8];
    logic        dn  [8];
    logic [15:0] wd  [8];
    bit          any_done;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(posedge clk);
    #2;
    clr   = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.instr_ready, 1'b1);
    chk("reset_psr", bus.psr, 5'b00000);
    chk("reset_we", bus.rf_we, 1'b0);

    preload(4'd1, 16'd10); preload(4'd2, 16'd10);
    issue(16'h0152);
    chk("add_we", cap_we, 1'b1);
    chk("add_waddr", cap_waddr, 4'd1);
    chk("add_wdata", cap_wdata, 16'd20);
    chk("add_psr", cap_psr, 5'b00000);

    preload(4'd0, 16'd0); preload(4'd1, 16'd1);
    issue(16'h00B1);
    chk("cmp_we", cap_we, 1'b0);
    chk("cmp_psr", cap_psr, 5'b10010);

    preload(4'd5, 16'hFFFF); preload(4'd6, 16'd1);
    issue(16'h0556);
    chk("addc_wdata", cap_wdata, 16'h0000);
    chk("addc_carry", cap_psr[0], 1'b1);
    preload(4'd3, 16'd1);
    issue(16'h537F);
`ifdef CARRY_CHAIN_EN
    chk("addi_chain", cap_wdata, 16'h0081);
`else
    chk("addi_chain", cap_wdata, 16'h0080);
`endif

    preload(4'd4, 16'd0);
    issue(16'h9401);
    chk("subi_1", cap_wdata, 16'hFFFF);
    preload(4'd4, 16'd0);
    issue(16'h94FF);
    chk("subi_m1", cap_wdata, 16'h0001);
    preload(4'd4, 16'h8000);
    issue(16'h9401);
    chk("subi_ovf", cap_psr[2], 1'b1);

    psr_before = bus.psr;
    issue(16'hF000);
    chk("ill_flag", cap_ill, 1'b1);
    chk("ill_we", cap_we, 1'b0);
    chk("ill_psr", cap_psr, psr_before);
    chk("ill_psr_lit", cap_psr, 5'b00100);

    preload(4'd1, 16'd3); preload(4'd2, 16'd2);
    issue(16'h8112);
    chk("shift_wdata", cap_wdata, 16'd12);

    // Two queued instructions with valid held high.
    preload(4'd1, 16'd3); preload(4'd2, 16'd5); preload(4'd7, 16'd9);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0152;
    @(posedge clk);
    #2 bus.instr = 16'h0792;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rdy[k] = bus.instr_ready;
      dn[k]  = bus.done;
      wd[k]  = bus.rf_wdata;
      if (k == 6) bus.instr_valid = 1'b0;
    end
    chk("hs_rdy_c1", rdy[0], 1'b0);
    chk("hs_rdy_c3", rdy[2], 1'b0);
    chk("hs_rdy_c4", rdy[3], 1'b1);
    chk("hs_rdy_c5", rdy[4], 1'b0);
    chk("hs_done1", dn[2], 1'b1);
    chk("hs_wdata1", wd[2], 16'd8);
    chk("hs_done2_c6", dn[5], 1'b0);
    chk("hs_done2", dn[6], 1'b1);
    chk("hs_wdata2", wd[6], 16'd4);

    // Reset during EXEC aborts the instruction.
    preload(4'd9, 16'd5); preload(4'd10, 16'd6);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h095A;
    @(posedge clk);
    #2 bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", bus.instr_ready, 1'b1);
    chk("rst_exec_we", bus.rf_we, 1'b0);
    chk("rst_exec_psr", bus.psr, 5'b00000);
    any_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.rf_we) any_done = 1'b1;
    end
    chk("rst_exec_nowb", any_done, 1'b0);
    chk("rst_exec_reg", regs[9], 16'd5);

    // Reset arriving during WB must block the write.
    preload(4'd11, 16'd7); preload(4'd12, 16'd1);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0B5C;
    @(posedge clk);
    #2 bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_wb_we", bus.rf_we, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_wb_reg", regs[11], 16'd7);
    chk("rst_wb_ready", bus.instr_ready, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
